pulse_stretch: RTL and testbench
================================

# pulse_stretch

Output-side counterpart to the input debouncer. It turns brief internal events into human-visible or externally-observable levels, such as LED blink, buzzer gate or a scope trigger. Each of `width` channels converts a rising edge on its input into an output pulse of guaranteed minimum length, followed by an optional hold-off window. The block sits between core logic, which produces single-cycle strobes, and the board output pins.

## Interface
Parameters:
- `width`, default 1: number of independent channels.
- `PRESCALE`, default 50000: clocks per tick; must be ≥1.
- `LENGTH`, default 20: active length in ticks; must be ≥1.
- `HOLDOFF`, default 4: hold-off length in ticks; must be ≥0.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in`, input, [width:1]: event inputs, synchronous to `clk`; the rising edge is significant.
- `out`, output, [width:1]: stretched pulses, registered.
- `busy`, output, [width:1]: channel is not IDLE (ACTIVE or HOLDOFF), registered.

## Operation
Prescaler:
- One free-running counter is shared by all channels and counts 0..PRESCALE-1, then wraps.
- `tick` is high for exactly one cycle when the count equals PRESCALE-1.
- With PRESCALE=1, `tick` is high every cycle.

Edge detect, per channel:
- `in_d` is a register holding the previous `in`.
- `rise = in & ~in_d`.

Channel FSM states are IDLE, ACTIVE and HOLDOFF. Each channel has a tick counter `cnt` of width `$clog2(max(LENGTH,HOLDOFF)+1)`.
- IDLE:
  - `rise` → ACTIVE, `cnt=LENGTH`. A coincident tick is not counted.
- ACTIVE:
  - On tick with `cnt>1`: `cnt--`.
  - On tick with `cnt==1`: go to HOLDOFF with `cnt=HOLDOFF`, or go directly to IDLE if HOLDOFF==0.
  - `rise` handling is set by the Configuration macro.
- HOLDOFF:
  - On tick with `cnt>1`: `cnt--`.
  - On tick with `cnt==1`: → IDLE.
  - `rise` is ignored and dropped; it is not queued.

Outputs are decoded from the next state and registered:
- `out` is high when the channel is in ACTIVE.
- `busy` is high when the channel is not in IDLE.

Channels are fully independent apart from the shared prescaler.

## Timing
- Reset: `out=0` and `busy=0` for all channels; states are IDLE, `cnt=0`, prescaler=0, `in_d=0`.
- Latency: `out` and `busy` rise on the clock edge that samples the first high cycle of `in`. They are visible in the cycle after `in` first goes high.
- Active duration in clocks is in the range ((LENGTH-1)·PRESCALE, LENGTH·PRESCALE].
  - It is exact when PRESCALE=1: `out` is high for exactly LENGTH cycles.
- Hold-off duration is HOLDOFF·PRESCALE clocks exactly, because it begins on a tick.
- An `in` held high does not retrigger. A new rise requires at least one low cycle.
- An `in` that is high at reset release produces one rise on the first clock and starts a stretch.
- Reset asserted mid-pulse forces `out`/`busy` low immediately (asynchronously). Operation resumes from IDLE.

## Configuration
Macro `PULSE_STRETCH_RETRIGGER_EN`:
- Defined: a `rise` in ACTIVE reloads `cnt=LENGTH`, extending the pulse. The reload has priority over a coincident tick. The `out` level stays high without a gap.
- Undefined: a `rise` in ACTIVE is ignored. The pulse ends exactly LENGTH ticks after entry.

## Structure
Package `pulse_stretch_pkg` holds:
- the state enum `ps_state_t`: IDLE=2'd0, ACTIVE=2'd1, HOLDOFF=2'd2;
- the counter-width function `ps_cnt_w(LENGTH,HOLDOFF)`.

Hierarchy:
- The top level `pulse_stretch` contains the shared prescaler and a generate loop over channels.
- The sub-module `pulse_stretch_chan` holds one channel's edge detect, FSM, counter and output registers. It takes `tick` as an input.

## Test plan
All scenarios use `width=2`.
1. Single strobe, PRESCALE=1, LENGTH=3, HOLDOFF=2: one-cycle high on in[1] → out[1] high exactly 3 cycles, busy[1] high exactly 5 cycles; out[2] and busy[2] stay 0.
2. Hold-off drop, PRESCALE=1, LENGTH=3, HOLDOFF=2: second strobe during HOLDOFF → no new pulse. A strobe 1 cycle after busy falls → new 3-cycle pulse.
3. Retrigger, PRESCALE=1, LENGTH=3, strobe at t0 and t2:
   - With the macro defined → out high continuously for 5 cycles.
   - With the macro undefined → out high for 3 cycles, and the second strobe has no effect.
4. Prescaled length, PRESCALE=4, LENGTH=3, HOLDOFF=0: strobes at each of the 4 prescaler phases → out length in {9,10,11,12} cycles, each value hit once. busy falls with out.
5. Level input and reset, PRESCALE=1, LENGTH=3: in[2] held high through reset release → exactly one 3-cycle pulse, no repeat while held. Then reset_n pulled low mid-pulse → out and busy are 0 in the same cycle, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// rtl/pulse_stretch_pkg.sv - shared state encoding and counter sizing for pulse_stretch
package pulse_stretch_pkg;

   // Channel state; the encoding is fixed so it stays stable across builds.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      HOLDOFF = 2'd2
   } ps_state_t;

   // The tick counter must hold the larger of the active and hold-off lengths.
   function automatic int ps_cnt_w(input int length, input int holdoff);
      int longest;
      longest = (length > holdoff) ? length : holdoff;
      return (longest > 0) ? $clog2(longest + 1) : 1;
   endfunction

endpackage

// File: rtl/pulse_stretch_chan.sv
// rtl/pulse_stretch_chan.sv - one channel: edge detect, IDLE/ACTIVE/HOLDOFF FSM, tick counter (PULSE_STRETCH_RETRIGGER_EN selects retrigger)
module pulse_stretch_chan
   import pulse_stretch_pkg::*;
#(
   parameter int LEN_TICKS  = 20,
   parameter int HOLD_TICKS = 4,
   parameter int CNT_W      = 5
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in,
   input  logic tick,
   output logic out,
   output logic busy
);

   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN_TICKS);
   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   ps_state_t        state;
   ps_state_t        state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             in_d;
   logic             rise;

   assign rise = in & ~in_d;

   // State, counter, edge-detect history and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         in_d  <= 1'b0;
         out   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         in_d  <= in;
         out   <= (state_n == ACTIVE);
         busy  <= (state_n != IDLE);
      end
   end

   // Next state and counter; a tick coincident with entry to ACTIVE is not counted.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (rise) begin
               state_n = ACTIVE;
               cnt_n   = LEN_C;
            end
         end
         ACTIVE: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
            if (rise) begin
               cnt_n = LEN_C;
            end else
`endif
            if (tick) begin
               if (cnt > ONE_C) begin
                  cnt_n = cnt - ONE_C;
               end else if (HOLD_TICKS == 0) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  state_n = HOLDOFF;
                  cnt_n   = HOLD_C;
               end
            end
         end
         HOLDOFF: begin
            // Rises here are dropped on purpose; nothing is queued.
            if (tick) begin
               if (cnt > ONE_C) begin
                  cnt_n = cnt - ONE_C;
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - multi-channel pulse stretcher with shared prescaler (option: PULSE_STRETCH_RETRIGGER_EN)
module pulse_stretch #(
   parameter int width    = 1,
   parameter int PRESCALE = 50000,
   parameter int LENGTH   = 20,
   parameter int HOLDOFF  = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [width:1]   in,
   output logic [width:1]   out,
   output logic [width:1]   busy
);

   import pulse_stretch_pkg::*;

   localparam int CNT_W = ps_cnt_w(LENGTH, HOLDOFF);
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps_cnt;
   logic            tick;

   // With PRESCALE=1 the counter sits at 0 and tick is high every cycle.
   assign tick = (ps_cnt == PS_LAST);

   // Free-running prescaler shared by every channel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps_cnt <= '0;
      end else if (tick) begin
         ps_cnt <= '0;
      end else begin
         ps_cnt <= ps_cnt + PS_W'(1);
      end
   end

   for (genvar i = 1; i <= width; i++) begin : g_chan
      pulse_stretch_chan #(
         .LEN_TICKS  (LENGTH),
         .HOLD_TICKS (HOLDOFF),
         .CNT_W      (CNT_W)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .in      (in[i]),
         .tick    (tick),
         .out     (out[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - scoreboard bench for pulse_stretch (honours PULSE_STRETCH_RETRIGGER_EN)
module tb_pulse_stretch;

   typedef struct {
      int sig;
      int len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_a;
   logic       rst_b;
   logic [2:1] in_a;
   logic [2:1] in_b;
   logic [2:1] out_a;
   logic [2:1] busy_a;
   logic [2:1] out_b;
   logic [2:1] busy_b;
   logic [7:0] mon;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    ps_model;
   int    run_len [8];
   string sig_name [8];
   int    t4_len [4];
   exp_t  exp_q [$];

   always #5 clk = ~clk;

   pulse_stretch #(.width(2), .PRESCALE(1), .LENGTH(3), .HOLDOFF(2)) u_a (
      .clk(clk), .reset_n(rst_a), .in(in_a), .out(out_a), .busy(busy_a)
   );

   pulse_stretch #(.width(2), .PRESCALE(4), .LENGTH(3), .HOLDOFF(0)) u_b (
      .clk(clk), .reset_n(rst_b), .in(in_b), .out(out_b), .busy(busy_b)
   );

   assign mon = {busy_b[2], out_b[2], busy_b[1], out_b[1],
                 busy_a[2], out_a[2], busy_a[1], out_a[1]};

   // Independent reference of the shared prescaler phase of instance b.
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) ps_model <= 0;
      else        ps_model <= (ps_model == 3) ? 0 : ps_model + 1;
   end

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic expect_pulse(input int s, input int len);
      exp_t e;
      e.sig = s;
      e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic pulse_done(input int s, input int len);
      int idx;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
         if (idx < 0 && exp_q[i].sig == s) idx = i;
      if (idx < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected pulse on %s: length %0d, none expected", sig_name[s], len);
      end else begin
         check({sig_name[s], " length"}, len, exp_q[idx].len);
         exp_q.delete(idx);
      end
   endtask

   // Monitor: measure every high run of each output and compare it with the scoreboard.
   initial begin
      for (int s = 0; s < 8; s++) run_len[s] = 0;
      forever begin
         @(negedge clk);
         for (int s = 0; s < 8; s++) begin
            if (mon[s]) begin
               run_len[s]++;
            end else if (run_len[s] != 0) begin
               pulse_done(s, run_len[s]);
               run_len[s] = 0;
            end
         end
      end
   end

   task automatic pulse_a(input int ch);
      @(negedge clk);
      in_a[ch] = 1'b1;
      @(negedge clk);
      in_a[ch] = 1'b0;
   endtask

   task automatic strobe_b_phase(input int p);
      @(negedge clk);
      while (ps_model != p) @(negedge clk);
      in_b[1] = 1'b1;
      @(negedge clk);
      in_b[1] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sig_name = '{"a.out[1]", "a.busy[1]", "a.out[2]", "a.busy[2]",
                   "b.out[1]", "b.busy[1]", "b.out[2]", "b.busy[2]"};
      t4_len   = '{11, 10, 9, 12};
      in_a  = '0;
      in_b  = '0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) @(negedge clk);
      check("reset out_a",  int'(out_a),  0);
      check("reset busy_a", int'(busy_a), 0);
      check("reset out_b",  int'(out_b),  0);
      check("reset busy_b", int'(busy_b), 0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);

      // Single strobe: 3 cycles active, 5 cycles busy.
      expect_pulse(0, 3);
      expect_pulse(1, 5);
      pulse_a(1);
      repeat (10) @(negedge clk);

      // Strobe during hold-off is dropped; strobe one cycle after busy falls starts anew.
      expect_pulse(0, 3);
      expect_pulse(1, 5);
      expect_pulse(0, 3);
      expect_pulse(1, 5);
      pulse_a(1);
      repeat (2) @(negedge clk);
      pulse_a(1);
      pulse_a(1);
      repeat (12) @(negedge clk);

      // Strobes two cycles apart.
`ifdef PULSE_STRETCH_RETRIGGER_EN
      expect_pulse(0, 5);
      expect_pulse(1, 7);
`else
      expect_pulse(0, 3);
      expect_pulse(1, 5);
`endif
      pulse_a(1);
      pulse_a(1);
      repeat (12) @(negedge clk);

      // Prescaled length at each prescaler phase.
      for (int p = 0; p < 4; p++) begin
         expect_pulse(4, t4_len[p]);
         expect_pulse(5, t4_len[p]);
         strobe_b_phase(p);
         repeat (16) @(negedge clk);
      end

      // Level input high through reset release: exactly one pulse.
      rst_a   = 1'b0;
      in_a[2] = 1'b1;
      repeat (2) @(negedge clk);
      expect_pulse(2, 3);
      expect_pulse(3, 5);
      rst_a = 1'b1;
      repeat (15) @(negedge clk);
      in_a[2] = 1'b0;

      // Reset mid-pulse clears outputs at once.
      expect_pulse(2, 2);
      expect_pulse(3, 2);
      pulse_a(2);
      @(negedge clk);
      #1 rst_a = 1'b0;
      #1;
      check("async reset out_a",  int'(out_a),  0);
      check("async reset busy_a", int'(busy_a), 0);
      @(negedge clk);
      rst_a = 1'b1;
      repeat (2) @(negedge clk);

      // After reset the channel starts cleanly from IDLE.
      expect_pulse(2, 3);
      expect_pulse(3, 5);
      pulse_a(2);
      repeat (12) @(negedge clk);

      check("scoreboard entries left", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
